// File: rtl/bet_entry_unit.sv
// Bet entry stage: button-driven editing of bet amount/count while the game
// FSM is in its bet-input state. Clamps the amount to the live balance and the
// display limit, then confirms/rejects and freezes the bet for the round.
module bet_entry_unit #(
    parameter logic [3:0]  S_BET_INPUT   = 4'd1,
    parameter logic [15:0] MIN_BET       = 16'd1,
    parameter logic [15:0] MAX_BET       = 16'd9999,
    parameter logic [23:0] HOLD_CYCLES   = 24'd25_000_000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [15:0] current_money,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_step,
    input  logic        btn_count,
    input  logic        btn_confirm,
    output logic [15:0] bet_amount,
    output logic [2:0]  bet_count,
    output logic [1:0]  step_sel,
    output logic        bet_valid,
    output logic        bet_locked,
    output logic        err_funds
);

    typedef enum logic [1:0] {IDLE, EDIT, LOCKED} fsm_t;

    // Button bit order: 0=up 1=down 2=step 3=count 4=confirm
    localparam int B_UP      = 0;
    localparam int B_DOWN    = 1;
    localparam int B_STEP    = 2;
    localparam int B_COUNT   = 3;
    localparam int B_CONFIRM = 4;

    fsm_t        fsm_reg, fsm_next;
    logic [3:0]  prev_state_reg;
    logic [4:0]  btn_prev_reg;
    logic [4:0]  btn_now;
    logic [4:0]  btn_rise;
    logic [1:0]  rpt_fire;

    logic [15:0] amount_reg, amount_next;
    logic [2:0]  count_reg, count_next;
    logic [1:0]  step_reg, step_next;
    logic        valid_reg, valid_next;
    logic        locked_reg, locked_next;
    logic        err_reg, err_next;

    logic [15:0] limit;
    logic [15:0] step_val;
    logic [16:0] up_sum;
    logic [15:0] up_result;
    logic [15:0] down_result;
    logic        entry;
    logic        ev_up, ev_down;

    assign btn_now  = {btn_confirm, btn_count, btn_step, btn_down, btn_up};
    assign btn_rise = btn_now & ~btn_prev_reg;

    // Auto-repeat counters for up/down: count high cycles while editing; after the
    // first repeat the counter is rewound so the next one lands REPEAT_CYCLES later.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rpt
            logic [23:0] cnt_reg;
            logic [23:0] cnt_inc;
            logic        counting;

            assign cnt_inc      = cnt_reg + 24'd1;
            assign counting     = (fsm_reg == EDIT) && btn_now[gi];
            assign rpt_fire[gi] = counting && (cnt_inc == HOLD_CYCLES);

            // Hold-time counter, cleared on release or outside editing
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= 24'd0;
                end else if (counting) begin
                    cnt_reg <= (cnt_inc == HOLD_CYCLES) ? (HOLD_CYCLES - REPEAT_CYCLES) : cnt_inc;
                end else begin
                    cnt_reg <= 24'd0;
                end
            end
        end
    endgenerate

    assign ev_up   = btn_rise[B_UP]   | rpt_fire[B_UP];
    assign ev_down = btn_rise[B_DOWN] | rpt_fire[B_DOWN];

    // Live clamp limit and the arithmetic for one up/down step
    always_comb begin
        limit = (current_money < MAX_BET) ? current_money : MAX_BET;
        case (step_reg)
            2'd1:    step_val = 16'd10;
            2'd2:    step_val = 16'd100;
            default: step_val = 16'd1;
        endcase
        up_sum    = {1'b0, amount_reg} + {1'b0, step_val};
        up_result = (up_sum > {1'b0, limit}) ? limit : up_sum[15:0];
        if (amount_reg < MIN_BET) begin
            down_result = amount_reg;
        end else if ({1'b0, amount_reg} >= ({1'b0, step_val} + {1'b0, MIN_BET})) begin
            down_result = amount_reg - step_val;
        end else begin
            down_result = MIN_BET;
        end
        entry = (state == S_BET_INPUT) && (prev_state_reg != S_BET_INPUT);
    end

    // Next-state and output logic for the entry FSM
    always_comb begin
        fsm_next    = fsm_reg;
        amount_next = amount_reg;
        count_next  = count_reg;
        step_next   = step_reg;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        locked_next = locked_reg;
        case (fsm_reg)
            IDLE, LOCKED: begin
                if (entry) begin
                    fsm_next    = EDIT;
                    amount_next = (limit >= MIN_BET) ? MIN_BET : 16'd0;
                    count_next  = 3'd1;
                    step_next   = 2'd0;
                    locked_next = 1'b0;
                end
            end
            EDIT: begin
                if (btn_rise[B_CONFIRM]) begin
                    if ((amount_reg >= MIN_BET) && (amount_reg <= current_money)) begin
                        valid_next  = 1'b1;
                        locked_next = 1'b1;
                        fsm_next    = LOCKED;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (ev_up) begin
                    amount_next = up_result;
                end else if (ev_down) begin
                    amount_next = down_result;
                end else if (btn_rise[B_STEP]) begin
                    step_next = (step_reg == 2'd2) ? 2'd0 : step_reg + 2'd1;
                end else if (btn_rise[B_COUNT]) begin
                    count_next = (count_reg == 3'd4) ? 3'd1 : count_reg + 3'd1;
                end
                // Leaving bet input without an accepted confirm abandons the edit
                if ((fsm_next == EDIT) && (state != S_BET_INPUT)) begin
                    fsm_next    = IDLE;
                    locked_next = 1'b0;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // State, edge-detect history and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_reg        <= IDLE;
            prev_state_reg <= 4'd0;
            btn_prev_reg   <= 5'd0;
            amount_reg     <= 16'd0;
            count_reg      <= 3'd1;
            step_reg       <= 2'd0;
            valid_reg      <= 1'b0;
            locked_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            fsm_reg        <= fsm_next;
            prev_state_reg <= state;
            btn_prev_reg   <= btn_now;
            amount_reg     <= amount_next;
            count_reg      <= count_next;
            step_reg       <= step_next;
            valid_reg      <= valid_next;
            locked_reg     <= locked_next;
            err_reg        <= err_next;
        end
    end

    assign bet_amount = amount_reg;
    assign bet_count  = count_reg;
    assign step_sel   = step_reg;
    assign bet_valid  = valid_reg;
    assign bet_locked = locked_reg;
    assign err_funds  = err_reg;

endmodule
